// File: rtl/ssd_scroll_if.sv
// Bus between the scroll scheduler and its controller: message buffer
// write port, scroll controls, and the multiplexed display outputs.
interface ssd_scroll_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] msg_len;
    logic       start;
    logic       stop;
    logic       hold;
    logic [3:0] anodes;
    logic [3:0] char;
    logic [3:0] offset;
    logic       busy;
    logic       step_pulse;

    // Controller side: drives writes and scroll controls, observes the display.
    modport master (
        output wr_en, wr_addr, wr_data, msg_len, start, stop, hold,
        input  anodes, char, offset, busy, step_pulse
    );

    // Scheduler side.
    modport slave (
        input  wr_en, wr_addr, wr_data, msg_len, start, stop, hold,
        output anodes, char, offset, busy, step_pulse
    );
endinterface

// File: rtl/ssd_scroll_scheduler.sv
// Four-digit seven-segment scroll scheduler.
// Multiplexes a 16-entry message buffer across four active-low digit
// anodes and scrolls the message one position every FRAMES_PER_STEP
// full scan frames while in SCROLL.
// Optional feature: define SSD_SCROLL_BLANK_EN to blank all anodes during
// the first dwell cycle of every digit (anti-ghosting).
module ssd_scroll_scheduler #(
    parameter int DWELL           = 4096,
    parameter int FRAMES_PER_STEP = 64
) (
    input  logic        clk,
    input  logic        reset,
    ssd_scroll_if.slave bus
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCROLL = 2'd1;
    localparam logic [1:0] ST_PAUSE  = 2'd2;

    logic [3:0]    msg_buf_q [16];
    logic [3:0]    msg_buf_d [16];
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    offset_q, offset_d;
    logic          step_pulse_q, step_pulse_d;
    logic [3:0]    anodes_q, anodes_d;
    logic [3:0]    char_q, char_d;

    logic          dwell_wrap;
    logic          frame_end;
    logic [4:0]    len5;
    logic          off_ovf;
    logic [3:0]    eff_off;
    logic [4:0]    idx;
    logic [3:0]    digit_sel;

    assign dwell_wrap = (dwell_q == DWELL_LAST);
    assign frame_end  = dwell_wrap && (digit_q == 2'd0);
    assign len5       = {1'b0, bus.msg_len} + 5'd1;
    assign off_ovf    = ({1'b0, offset_q} >= len5);
    // A stale offset beyond a freshly shortened message is shown as 0,
    // matching the value it is forced to on the next edge.
    assign eff_off    = off_ovf ? 4'd0 : offset_q;

    // Message buffer write port; every address is writable in every state.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned and infers a latch.
        msg_buf_d = msg_buf_q;
        if (bus.wr_en) begin
            msg_buf_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Scan timing: dwell counter and digit index walking an3 -> an0.
    always_comb begin
        dwell_d = dwell_wrap ? '0 : dwell_q + DW'(1);
        digit_d = dwell_wrap ? digit_q - 2'd1 : digit_q;
    end

    // Character lookup for the digit currently selected: (offset + 3 - k) mod L.
    always_comb begin
        idx = {1'b0, eff_off} + {3'b000, 2'd3 - digit_q};
        // eff_off < L, so the sum is below L+3 and three conditional subtracts suffice even for L=1.
        for (int i = 0; i < 3; i++) begin
            if (idx >= len5) begin
                idx = idx - len5;
            end
        end
        char_d    = msg_buf_q[idx[3:0]];
        digit_sel = ~(4'b0001 << digit_q);
`ifdef SSD_SCROLL_BLANK_EN
        anodes_d  = (dwell_q == '0) ? 4'b1111 : digit_sel;
`else
        anodes_d  = digit_sel;
`endif
    end

    // Scroll FSM: state transitions, frame counting and offset advance.
    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        frame_d      = frame_q;
        step_pulse_d = 1'b0;

        if (bus.stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (bus.start) state_d = ST_SCROLL;
                ST_SCROLL: if (bus.hold)  state_d = ST_PAUSE;
                ST_PAUSE:  if (!bus.hold) state_d = ST_SCROLL;
                default:   state_d = ST_IDLE;
            endcase
        end

        if (bus.stop || state_q == ST_IDLE) begin
            offset_d = 4'd0;
            frame_d  = '0;
        end else begin
            if (off_ovf) begin
                offset_d = 4'd0;
            end
            if (state_q == ST_SCROLL && frame_end) begin
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    if (!off_ovf) begin
                        offset_d     = (offset_q == bus.msg_len) ? 4'd0 : offset_q + 4'd1;
                        step_pulse_d = 1'b1;
                    end
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end
        end
    end

    // Message buffer storage, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the buffer is cleared on reset because a cleared message is visible behaviour, not just hygiene.
            for (int i = 0; i < 16; i++) begin
                msg_buf_q[i] <= 4'd0;
            end
        end else begin
            msg_buf_q <= msg_buf_d;
        end
    end

    // Scan, FSM and display registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            dwell_q      <= '0;
            digit_q      <= 2'd3;
            frame_q      <= '0;
            state_q      <= ST_IDLE;
            offset_q     <= 4'd0;
            step_pulse_q <= 1'b0;
            anodes_q     <= 4'b1111;
            char_q       <= 4'd0;
        end else begin
            dwell_q      <= dwell_d;
            digit_q      <= digit_d;
            frame_q      <= frame_d;
            state_q      <= state_d;
            offset_q     <= offset_d;
            step_pulse_q <= step_pulse_d;
            anodes_q     <= anodes_d;
            char_q       <= char_d;
        end
    end

    assign bus.anodes     = anodes_q;
    assign bus.char       = char_q;
    assign bus.offset     = offset_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.step_pulse = step_pulse_q;

endmodule

// File: doc/ssd_scroll_scheduler.md
SSD_SCROLL_SCHEDULER -- requirements
Module: ssd_scroll_scheduler

Interface
REQ-001 Parameter DWELL, default 4096: clk cycles each digit stays selected (min 2).
REQ-002 Parameter FRAMES_PER_STEP, default 64: full four-digit scan frames per scroll step (min 1).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write strobe into message buffer.
REQ-006 wr_addr  input  4  message buffer write address.
REQ-007 wr_data  input  4  character code written.
REQ-008 msg_len  input  4  message length minus one (L = msg_len+1, 1..16).
REQ-009 start  input  1  single-cycle pulse: begin/resume scrolling.
REQ-010 stop  input  1  single-cycle pulse: end scrolling, offset to 0.
REQ-011 hold  input  1  level: freeze offset while high during scrolling.
REQ-012 anodes  output  4  digit enables {an3,an2,an1,an0}, active-low.
REQ-013 char  output  4  character code for currently enabled digit, to LED decoder.
REQ-014 offset  output  4  message index shown on an3.
REQ-015 busy  output  1  high in SCROLL or PAUSE.
REQ-016 step_pulse  output  1  one-cycle pulse when offset advances.

Function
REQ-017 Buffer: 16 x 4-bit registers; wr_en writes wr_data at wr_addr on the clock edge; any address legal in any state.
REQ-018 Scan: dwell counter counts 0..DWELL-1; at DWELL-1 it wraps and digit index advances an3->an2->an1->an0->an3.
REQ-019 Frame end = dwell wrap while an0 selected; frame counter counts 0..FRAMES_PER_STEP-1 and wraps there.
REQ-020 Digit k (3=an3 .. 0=an0) shows buffer[(offset + 3 - k) mod L]; sum formed 5 bits wide, L subtracted while >= L.
REQ-021 anodes and char registered, updated same edge; exactly one anode low outside blanking.
REQ-022 Write latency: written value appears on char no earlier than edge after the write, next time that digit is driven.
REQ-023 FSM states IDLE, SCROLL, PAUSE; IDLE: offset held 0, frame counter held 0, scan still runs.
REQ-024 IDLE -start-> SCROLL; SCROLL -hold high-> PAUSE; PAUSE -hold low-> SCROLL; SCROLL/PAUSE -stop-> IDLE with offset 0 next cycle.
REQ-025 stop and start same cycle: stop wins, result IDLE.
REQ-026 SCROLL: at frame end with frame counter at FRAMES_PER_STEP-1, offset advances; offset L-1 wraps to 0; step_pulse high one cycle.
REQ-027 PAUSE: frame counter and offset frozen; resume continues from frozen count.
REQ-028 msg_len change making offset >= L: offset forced to 0 next cycle, no step_pulse.
REQ-029 L=1: offset stays 0; all four digits show buffer[0].

Reset
REQ-030 reset low asynchronously forces: state IDLE, anodes 4'b1111, char 0, offset 0, busy 0, step_pulse 0, dwell/frame counters 0, digit index an3, buffer all 0.
REQ-031 After reset release, first enabled digit is an3 on the first clk edge.
REQ-032 Reset mid-scroll discards offset and state; no partial write commits on an edge with reset low.

Configuration
REQ-033 Macro SSD_SCROLL_BLANK_EN defined: anodes = 4'b1111 during dwell count 0 of each digit (anti-ghosting), char already updated.
REQ-034 Macro absent: anodes switch directly between digits, no blank cycle; all else identical.

Verification (DWELL=4, FRAMES_PER_STEP=2)
REQ-035 Reset, write buffer[i]=i, msg_len=15, idle -> anodes cycle 0111,1011,1101,1110 every 4 cycles, chars 0,1,2,3.
REQ-036 start -> step_pulse every 32 cycles; after 16 steps offset wraps 15->0; an3 char tracks offset.
REQ-037 msg_len=4, offset=3 -> digits show 3,4,0,1; set msg_len=1 -> offset 0 next cycle.
REQ-038 hold high 100 cycles in SCROLL -> no step_pulse, offset constant; hold low -> steps resume; start+stop same cycle -> IDLE, offset 0.
REQ-039 reset asserted mid-dwell in SCROLL -> anodes 1111, busy 0, buffer cleared immediately, without clk edge.
REQ-040 With SSD_SCROLL_BLANK_EN: anodes 1111 one cycle of every 4; without: never 1111 after first edge.
